// File: rtl/univ_fifo_sync_ext_if.sv
// Producer/consumer bundle for the extended synchronous FIFO.
// The master side drives requests and data; the slave side (the FIFO) returns data, flags and count.
interface univ_fifo_sync_ext_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic                  cs;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [AW:0]           count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output cs, wr_en, rd_en, data_in, clr_err,
    input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  cs, wr_en, rd_en, data_in, clr_err,
    output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/univ_fifo_sync_ext.sv
// Single-clock circular-buffer FIFO: wrap-bit pointers, programmable almost flags,
// sticky error flags and a registered or first-word-fall-through read port.
module univ_fifo_sync_ext #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  univ_fifo_sync_ext_if.slave   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [AW:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt;
  logic        ovf_q, ovf_d, udf_q, udf_d;
  logic        empty, full, pop_ok, push_ok;

  // Extra wrap bit lets the subtraction distinguish full from empty.
  assign cnt   = wr_ptr_q - rd_ptr_q;
  assign empty = (cnt == '0);
  assign full  = (cnt == DEPTH_C);

  assign pop_ok  = bus.cs & bus.rd_en & ~empty;
  assign push_ok = bus.cs & bus.wr_en & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    // Clear first so a same-cycle error event overrides it.
    if (bus.cs & bus.clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.cs & bus.wr_en & ~push_ok) ovf_d = 1'b1;
    if (bus.cs & bus.rd_en & empty)    udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= bus.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = mem_q[rd_ptr_q[AW-1:0]];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q, dout_d;
      always_comb begin
        dout_d = dout_q;
        if (pop_ok) dout_d = mem_q[rd_ptr_q[AW-1:0]];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
      end
      assign bus.data_out = dout_q;
    end
  endgenerate

  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (cnt <= AE_C);
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.count        = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_univ_fifo_sync_ext.sv
// Drives a registered-read and an FWFT instance with identical stimulus and
// checks both against a queue-based reference model.
module tb_univ_fifo_sync_ext;
  localparam int DW = 32;
  localparam int D  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  univ_fifo_sync_ext_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) b0 ();
  univ_fifo_sync_ext_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) b1 ();

  univ_fifo_sync_ext #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2))
    u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  univ_fifo_sync_ext #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf;
  logic [DW-1:0] m_dout;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit cs, input bit wr, input bit rd, input logic [DW-1:0] din, input bit clr);
    b0.cs = cs; b0.wr_en = wr; b0.rd_en = rd; b0.data_in = din; b0.clr_err = clr;
    b1.cs = cs; b1.wr_en = wr; b1.rd_en = rd; b1.data_in = din; b1.clr_err = clr;
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = '0;
  endtask

  // Occupancy-level reference: pop frees a slot for a same-cycle push; errors beat clear.
  task automatic model_step(input bit cs, input bit wr, input bit rd, input logic [DW-1:0] din, input bit clr);
    bit pop, push, oset, uset;
    pop  = cs && rd && (q.size() > 0);
    push = cs && wr && ((q.size() < D) || pop);
    oset = cs && wr && !push;
    uset = cs && rd && (q.size() == 0);
    if (pop)  m_dout = q.pop_front();
    if (push) q.push_back(din);
    if (cs && clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (oset) m_ovf = 1'b1;
    if (uset) m_udf = 1'b1;
  endtask

  task automatic check_all();
    chk("count",     32'(b0.count),        32'(q.size()));
    chk("count_fw",  32'(b1.count),        32'(q.size()));
    chk("empty",     32'(b0.empty),        32'(q.size() == 0));
    chk("full",      32'(b0.full),         32'(q.size() == D));
    chk("almost_e",  32'(b0.almost_empty), 32'(q.size() <= 2));
    chk("almost_f",  32'(b0.almost_full),  32'(q.size() >= 6));
    chk("overflow",  32'(b0.overflow),     32'(m_ovf));
    chk("underflow", 32'(b0.underflow),    32'(m_udf));
    chk("ovf_fw",    32'(b1.overflow),     32'(m_ovf));
    chk("udf_fw",    32'(b1.underflow),    32'(m_udf));
    chk("dout_reg",  b0.data_out,          m_dout);
    if (q.size() > 0) chk("dout_fwft", b1.data_out, q[0]);
  endtask

  // Called at a falling edge; returns at the next falling edge with inputs idle.
  task automatic cyc(input bit cs, input bit wr, input bit rd, input logic [DW-1:0] din, input bit clr);
    drive(cs, wr, rd, din, clr);
    @(posedge clk);
    model_step(cs, wr, rd, din, clr);
    #1;
    check_all();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Reset mid-burst
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'hA0 + i, 0);
    mid_reset();
    chk("rst_dout", b0.data_out, 32'h0);
    chk("rst_empty", 32'(b0.empty), 32'h1);

    // Fill, overflow, drain in order
    for (int i = 0; i < D; i++) cyc(1, 1, 0, 32'h10 + i, 0);
    cyc(1, 1, 0, 32'h99, 0);
    chk("ovf_9th", 32'(b0.overflow), 32'h1);
    for (int i = 0; i < D; i++) begin
      cyc(1, 0, 1, '0, 0);
      chk("drain", b0.data_out, 32'h10 + i);
    end
    cyc(1, 0, 0, '0, 1);

    // Full with simultaneous read/write
    for (int i = 0; i < D; i++) cyc(1, 1, 0, 32'h10 + i, 0);
    cyc(1, 1, 1, 32'hAA, 0);
    chk("full_rw_cnt", 32'(b0.count), 32'd8);
    chk("full_rw_pop", b0.data_out, 32'h10);
    for (int i = 1; i < D; i++) cyc(1, 0, 1, '0, 0);
    cyc(1, 0, 1, '0, 0);
    chk("aa_8th", b0.data_out, 32'hAA);

    // Empty with simultaneous read/write
    cyc(1, 1, 1, 32'h55, 0);
    chk("empty_rw_cnt", 32'(b0.count), 32'd1);
    chk("empty_rw_udf", 32'(b0.underflow), 32'h1);
    cyc(1, 0, 1, '0, 0);
    chk("pop_55", b0.data_out, 32'h55);
    cyc(1, 0, 0, '0, 1);

    // Wrap with steady occupancy of 3
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, $urandom, 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, 1, $urandom, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, '0, 0);

    // FWFT visibility, chip-select gating, clear versus concurrent set
    cyc(1, 1, 0, 32'h33, 0);
    chk("fwft_33", b1.data_out, 32'h33);
    for (int i = 1; i < D; i++) cyc(1, 1, 0, $urandom, 0);
    cyc(0, 1, 1, 32'hDEAD, 1);
    cyc(1, 1, 0, 32'h77, 0);
    cyc(1, 1, 0, 32'h78, 1);
    chk("ovf_wins", 32'(b0.overflow), 32'h1);
    cyc(0, 0, 0, '0, 1);
    chk("cs0_hold", 32'(b0.overflow), 32'h1);
    cyc(1, 0, 0, '0, 1);
    chk("clr", 32'(b0.overflow), 32'h0);

    // Randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
